// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - decoded MIDI message types shared with the MIDI decoder
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF,
        NOTE_ON,
        POLY_PRESSURE,
        CONTROL_CHANGE,
        PROGRAM_CHANGE,
        CHANNEL_PRESSURE,
        PITCH_BEND,
        SYSTEM
    } midi_kind_t;

    // data1 carries the controller number and data2 the 7-bit value for CONTROL_CHANGE
    typedef struct packed {
        midi_kind_t  kind;
        logic [3:0]  channel;
        logic [6:0]  data1;
        logic [6:0]  data2;
    } message_t;

endpackage

// File: rtl/parameter_bank_pkg.sv
// rtl/parameter_bank_pkg.sv - parameter indices, controller map and defaults for parameter_bank
package parameter_bank_pkg;

    localparam int NUM_PARAMS  = 7;
    localparam int VALUE_WIDTH = 14;

    typedef enum logic [2:0] {
        P_TEMPO,
        P_UNISON,
        P_ATTACK,
        P_DECAY,
        P_SUSTAIN,
        P_RELEASE,
        P_VOLUME
    } param_idx_t;

    // MSB controller numbers; the LSB of each pair sits 32 above
    localparam logic [6:0] PARAM_CC [NUM_PARAMS] = '{
        7'd3, 7'd9, 7'd14, 7'd15, 7'd20, 7'd21, 7'd7
    };

    localparam logic [VALUE_WIDTH-1:0] PARAM_DEFAULT [NUM_PARAMS] = '{
        14'd8192, 14'd1, 14'd1024, 14'd2048, 14'd12288, 14'd4096, 14'd0
    };

    localparam logic [6:0] CC_RESET_ALL = 7'd121;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } bank_state_t;

endpackage

// File: rtl/param_slew.sv
// rtl/param_slew.sv - one combinational step of current toward target, bounded by STEP
module param_slew #(
    parameter int VALUE_W = 14,
    parameter int STEP    = 64
) (
    input  logic [VALUE_W-1:0] current,
    input  logic [VALUE_W-1:0] target,
    output logic [VALUE_W-1:0] value_next
);

    localparam logic [VALUE_W-1:0] STEP_V = VALUE_W'(STEP);

    always_comb begin
        value_next = current;
        if (target > current) begin
            value_next = (target - current > STEP_V) ? current + STEP_V : target;
        end else if (target < current) begin
            value_next = (current - target > STEP_V) ? current - STEP_V : target;
        end
    end

endmodule

// File: rtl/parameter_bank.sv
// rtl/parameter_bank.sv - per-channel 14-bit synth parameter store with CC121 clear
// Optional feature: PARAM_SMOOTH_EN (round-robin slew of current toward target).
module parameter_bank
    import midi_pkg::*;
    import parameter_bank_pkg::*;
#(
    parameter int N_CHANNELS  = 4,
    parameter int N_PARAMS    = NUM_PARAMS,
    parameter int VALUE_W     = VALUE_WIDTH,
    parameter int SMOOTH_STEP = 64,
    localparam int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int P_W        = $clog2(N_PARAMS)
) (
    input  logic               clock_50_000_000,
    input  logic               reset,
    input  message_t           message,
    input  logic               message_ready,
    input  logic [CH_W-1:0]    rd_channel,
    input  logic [P_W-1:0]     rd_param,
    output logic [VALUE_W-1:0] rd_value,
    output logic               update_valid,
    output logic [CH_W-1:0]    update_channel,
    output logic [P_W-1:0]     update_param,
    output logic               busy
);

    logic [VALUE_W-1:0] target  [N_CHANNELS][N_PARAMS];
    logic [VALUE_W-1:0] current [N_CHANNELS][N_PARAMS];

    bank_state_t     state, state_next;
    logic [CH_W-1:0] clr_ch;
    logic [P_W-1:0]  clr_p;

    logic            pend_valid;
    logic [CH_W-1:0] pend_ch;
    logic [P_W-1:0]  pend_p;

    logic            accept, is_reset_all, hit_msb, hit_lsb, lsb_ok;
    logic [P_W-1:0]  hit_p;
    logic [CH_W-1:0] msg_ch;

    assign msg_ch       = message.channel[CH_W-1:0];
    assign accept       = message_ready && (state == ST_IDLE) &&
                          (message.kind == CONTROL_CHANGE) &&
                          (int'(message.channel) < N_CHANNELS);
    assign is_reset_all = (message.data1 == CC_RESET_ALL);
    assign lsb_ok       = hit_lsb && pend_valid && (pend_ch == msg_ch) && (pend_p == hit_p);
    assign busy         = (state == ST_CLEAR);

    always_comb begin
        hit_msb = 1'b0;
        hit_lsb = 1'b0;
        hit_p   = '0;
        for (int p = 0; p < N_PARAMS; p++) begin
            if (message.data1 == PARAM_CC[p]) begin
                hit_msb = 1'b1;
                hit_p   = P_W'(p);
            end
            if (message.data1 == PARAM_CC[p] + 7'd32) begin
                hit_lsb = 1'b1;
                hit_p   = P_W'(p);
            end
        end
    end

    always_ff @(posedge clock_50_000_000) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && is_reset_all) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_p == P_W'(N_PARAMS - 1)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

`ifdef PARAM_SMOOTH_EN
    logic [CH_W-1:0]    scan_ch;
    logic [P_W-1:0]     scan_p;
    logic [VALUE_W-1:0] slew_value;

    param_slew #(
        .VALUE_W (VALUE_W),
        .STEP    (SMOOTH_STEP)
    ) u_slew (
        .current    (current[scan_ch][scan_p]),
        .target     (target[scan_ch][scan_p]),
        .value_next (slew_value)
    );
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                for (int p = 0; p < N_PARAMS; p++) begin
                    target[c][p]  <= PARAM_DEFAULT[p];
                    current[c][p] <= PARAM_DEFAULT[p];
                end
            end
            pend_valid     <= 1'b0;
            pend_ch        <= '0;
            pend_p         <= '0;
            clr_ch         <= '0;
            clr_p          <= '0;
            rd_value       <= '0;
            update_valid   <= 1'b0;
            update_channel <= '0;
            update_param   <= '0;
`ifdef PARAM_SMOOTH_EN
            scan_ch        <= '0;
            scan_p         <= '0;
`endif
        end else begin
            update_valid <= 1'b0;
            if (int'(rd_param) < N_PARAMS && int'(rd_channel) < N_CHANNELS)
                rd_value <= current[rd_channel][rd_param];
            else
                rd_value <= '0;

`ifdef PARAM_SMOOTH_EN
            current[scan_ch][scan_p] <= slew_value;
            if (scan_p == P_W'(N_PARAMS - 1)) begin
                scan_p  <= '0;
                scan_ch <= (scan_ch == CH_W'(N_CHANNELS - 1)) ? '0 : scan_ch + 1'b1;
            end else begin
                scan_p <= scan_p + 1'b1;
            end
`endif

            case (state)
                ST_IDLE: begin
                    if (accept && is_reset_all) begin
                        clr_ch <= msg_ch;
                        clr_p  <= '0;
                    end else if (accept && hit_msb) begin
                        target[msg_ch][hit_p] <= {message.data2, 7'b0};
`ifndef PARAM_SMOOTH_EN
                        current[msg_ch][hit_p] <= {message.data2, 7'b0};
`endif
                        pend_valid     <= 1'b1;
                        pend_ch        <= msg_ch;
                        pend_p         <= hit_p;
                        update_valid   <= 1'b1;
                        update_channel <= msg_ch;
                        update_param   <= hit_p;
                    end else if (accept && lsb_ok) begin
                        target[msg_ch][hit_p][6:0] <= message.data2;
`ifndef PARAM_SMOOTH_EN
                        current[msg_ch][hit_p] <= {target[msg_ch][hit_p][VALUE_W-1:7], message.data2};
`endif
                        update_valid   <= 1'b1;
                        update_channel <= msg_ch;
                        update_param   <= hit_p;
                    end
                end
                ST_CLEAR: begin
                    // Placed after the scanner so a clear of the visited slot wins without ramping
                    target[clr_ch][clr_p]  <= PARAM_DEFAULT[clr_p];
                    current[clr_ch][clr_p] <= PARAM_DEFAULT[clr_p];
                    update_valid   <= 1'b1;
                    update_channel <= clr_ch;
                    update_param   <= clr_p;
                    clr_p          <= clr_p + 1'b1;
                    if (pend_valid && pend_ch == clr_ch) pend_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parameter_bank.sv
// tb/tb_parameter_bank.sv - directed self-checking bench for parameter_bank
module tb_parameter_bank;
    import midi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    message_t    message;
    logic        message_ready = 1'b0;
    logic [1:0]  rd_channel = '0;
    logic [2:0]  rd_param = '0;
    logic [13:0] rd_value;
    logic        update_valid;
    logic [1:0]  update_channel;
    logic [2:0]  update_param;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int exp_v [4][7];
    int prev, peak;

    localparam int DEF [7] = '{8192, 1, 1024, 2048, 12288, 4096, 0};

    parameter_bank dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .message          (message),
        .message_ready    (message_ready),
        .rd_channel       (rd_channel),
        .rd_param         (rd_param),
        .rd_value         (rd_value),
        .update_valid     (update_valid),
        .update_channel   (update_channel),
        .update_param     (update_param),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input midi_kind_t k, input int ch, input int d1, input int d2);
        message.kind    = k;
        message.channel = 4'(ch);
        message.data1   = 7'(d1);
        message.data2   = 7'(d2);
        message_ready   = 1'b1;
        @(negedge clk);
        message_ready   = 1'b0;
    endtask

    task automatic expect_upd(input string tag, input logic v, input int ch, input int p);
        chk({tag, "_valid"}, update_valid, v);
        if (v) begin
            chk({tag, "_chan"}, update_channel, ch);
            chk({tag, "_param"}, update_param, p);
        end
    endtask

    task automatic chk_rd(input string tag, input int ch, input int p, input int expv);
        rd_channel = 2'(ch);
        rd_param   = 3'(p);
        @(negedge clk);
        chk(tag, rd_value, expv);
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 7; p++)
                chk_rd($sformatf("%s_c%0d_p%0d", tag, c, p), c, p, exp_v[c][p]);
    endtask

    task automatic settle();
`ifdef PARAM_SMOOTH_EN
        cyc(260 * 28);
`endif
    endtask

    initial begin
        message = '0;
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 7; p++)
                exp_v[c][p] = DEF[p];

        cyc(3);
        reset = 1'b0;
        chk("rst_rd_value", rd_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd_valid", update_valid, 0);
        chk("rst_upd_chan", update_channel, 0);
        chk("rst_upd_param", update_param, 0);
        check_all("rst");

        // Channel 1 TEMPO MSB=10 then LSB=5 -> 10*128+5
        send(CONTROL_CHANGE, 1, 3, 10);
        expect_upd("tempo_msb", 1'b1, 1, 0);
        send(CONTROL_CHANGE, 1, 35, 5);
        expect_upd("tempo_lsb", 1'b1, 1, 0);
        exp_v[1][0] = 1285;
        settle();
        chk_rd("tempo_c1", 1, 0, 1285);
        chk_rd("tempo_c0", 0, 0, 8192);

        // Messages that must be ignored
        send(CONTROL_CHANGE, 4, 3, 99);
        expect_upd("ign_chan4", 1'b0, 0, 0);
        send(NOTE_ON, 0, 3, 50);
        expect_upd("ign_note_on", 1'b0, 0, 0);
        send(CONTROL_CHANGE, 0, 90, 64);
        expect_upd("ign_cc90", 1'b0, 0, 0);
        send(CONTROL_CHANGE, 0, 41, 7);
        expect_upd("ign_orphan_lsb", 1'b0, 0, 0);
        check_all("ign");

        // Interleaved pairs: the ATTACK LSB loses its pending MSB
        send(CONTROL_CHANGE, 0, 14, 30);
        expect_upd("atk_msb", 1'b1, 0, 2);
        send(CONTROL_CHANGE, 0, 15, 40);
        expect_upd("dec_msb", 1'b1, 0, 3);
        send(CONTROL_CHANGE, 0, 46, 1);
        expect_upd("atk_lsb_stale", 1'b0, 0, 0);
        exp_v[0][2] = 3840;
        exp_v[0][3] = 5120;
        settle();
        chk_rd("atk_c0", 0, 2, 3840);
        chk_rd("dec_c0", 0, 3, 5120);

        // Channel 2 dirtied, then reset-all controllers
        send(CONTROL_CHANGE, 2, 20, 5);
        expect_upd("c2_sus", 1'b1, 2, 4);
        send(CONTROL_CHANGE, 2, 7, 3);
        expect_upd("c2_vol", 1'b1, 2, 6);
        send(CONTROL_CHANGE, 2, 3, 1);
        expect_upd("c2_tempo_msb", 1'b1, 2, 0);
        send(CONTROL_CHANGE, 2, 35, 2);
        expect_upd("c2_tempo_lsb", 1'b1, 2, 0);
        exp_v[2][4] = 640;
        exp_v[2][6] = 384;
        exp_v[2][0] = 130;
        settle();
        check_all("pre_clr");

        send(CONTROL_CHANGE, 2, 121, 0);
        chk("clr_busy_rise", busy, 1);
        chk("clr_no_upd_on_accept", update_valid, 0);
        message.kind    = CONTROL_CHANGE;
        message.channel = 4'd0;
        message.data1   = 7'd7;
        message.data2   = 7'd77;
        message_ready   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            message_ready = 1'b0;
            expect_upd($sformatf("clr_p%0d", k), 1'b1, 2, k);
            chk($sformatf("clr_busy_p%0d", k), busy, (k < 6) ? 1 : 0);
        end
        @(negedge clk);
        chk("clr_done_upd", update_valid, 0);
        chk("clr_done_busy", busy, 0);
        for (int p = 0; p < 7; p++) exp_v[2][p] = DEF[p];
        check_all("clr");
        send(CONTROL_CHANGE, 2, 35, 9);
        expect_upd("clr_pending_gone", 1'b0, 0, 0);

        // Read and write of the same slot in one cycle returns the old value
        rd_channel = 2'd0;
        rd_param   = 3'd1;
        cyc(1);
        send(CONTROL_CHANGE, 0, 9, 9);
        chk("rbw_old", rd_value, 1);
        exp_v[0][1] = 1152;
`ifndef PARAM_SMOOTH_EN
        @(negedge clk);
        chk("rbw_new", rd_value, 1152);
`else
        settle();
        chk_rd("rbw_new", 0, 1, 1152);
`endif

`ifdef PARAM_SMOOTH_EN
        // VOLUME ramps 0 -> 16256 by 64 per full scan, then reset mid-ramp
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        rd_channel = 2'd0;
        rd_param   = 3'd6;
        send(CONTROL_CHANGE, 0, 7, 127);
        expect_upd("ramp_msb", 1'b1, 0, 6);
        cyc(28);
        prev = int'(rd_value);
        for (int i = 0; i < 20; i++) begin
            cyc(28);
            chk($sformatf("ramp_step%0d", i), int'(rd_value) - prev, 64);
            prev = int'(rd_value);
        end
        peak = 0;
        for (int i = 0; i < 260 * 28; i++) begin
            cyc(1);
            if (int'(rd_value) > peak) peak = int'(rd_value);
        end
        chk("ramp_end", rd_value, 16256);
        chk("ramp_peak", peak, 16256);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        send(CONTROL_CHANGE, 0, 7, 127);
        cyc(50 * 28);
        chk("ramp_mid_nonzero", (rd_value > 14'd0) ? 1 : 0, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(100);
        chk("ramp_reset_default", rd_value, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parameter_bank.md
# parameter_bank

Multi-channel successor to the single-set parameter controller. Sits after the MIDI decoder and holds one synth parameter set per MIDI channel, with 14-bit resolution from MSB/LSB control-change pairs. It supports the "reset all controllers" command per channel and provides a registered random-access read port for the voice and envelope engines.

## Interface
- N_CHANNELS, 4: MIDI channels stored, numbered 0..N_CHANNELS-1; range 1..16.
- N_PARAMS, 7: parameters per channel, in the order TEMPO, UNISON, ATTACK, DECAY, SUSTAIN, RELEASE, VOLUME.
- VALUE_W, 14: stored value width; fixed at 14 for MSB/LSB pairing.
- SMOOTH_STEP, 64: maximum change per visit when smoothing is compiled in.

Ports:
- clock_50_000_000, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- message, input, message_t: decoded MIDI message.
- message_ready, input, 1: one-cycle strobe qualifying `message`.
- rd_channel, input, $clog2(N_CHANNELS): read channel address.
- rd_param, input, $clog2(N_PARAMS): read parameter address.
- rd_value, output, VALUE_W: registered read data.
- update_valid, output, 1: one-cycle pulse when a stored target changes.
- update_channel, output, $clog2(N_CHANNELS): channel of the update.
- update_param, output, $clog2(N_PARAMS): parameter of the update.
- busy, output, 1: high while a channel clear is in progress.

## Operation
- Storage: `target[N_CHANNELS][N_PARAMS]` and `current[N_CHANNELS][N_PARAMS]`, each VALUE_W wide.
- Reset loads every entry with PARAM_DEFAULT[p]. Output reset values: rd_value=0, update_valid=0, update_channel=0, update_param=0, busy=0. The pending-MSB register is cleared.
- Message acceptance requires message_ready=1, busy=0, type CONTROL_CHANGE and channel < N_CHANNELS. Any other message is ignored with no state change.
- MSB write: the controller number matches PARAM_CC[p]. Set target = {data7, 7'b0}, record pending = {valid, channel, p}, and pulse update.
- LSB write: the controller number equals PARAM_CC[p]+32 and pending matches the same channel and p. Set target[6:0] = data7 and pulse update. An LSB with no matching pending MSB is ignored.
- A new MSB to a different slot replaces the pending register.
- Unmapped controller numbers are ignored.
- FSM states:
  - IDLE: accepts messages.
  - CLEAR: entered from IDLE on accepted controller 121 (reset all controllers). busy=1. Walks p=0..N_PARAMS-1, writing PARAM_DEFAULT[p] to target and current of that channel, one parameter per cycle. Each write pulses update with that parameter index. Pending is cleared if its channel matches. Returns to IDLE after the last parameter.
- Messages arriving in CLEAR are dropped. This is acceptable because MIDI byte spacing is far longer than N_PARAMS cycles.
- The read port returns `current`.

## Timing
- Write latency: message_ready at edge t; target is written and update_valid=1 during cycle t+1.
- Read latency: 1 cycle. Address presented at t gives rd_value after edge t+1.
- A read and a write to the same slot in the same cycle returns the old value (read-before-write).
- CLEAR lasts exactly N_PARAMS cycles: busy rises the cycle after acceptance and falls after the last write.
- Reset has priority over every other event. Reset during CLEAR aborts it and restores all defaults.

## Configuration
- PARAM_SMOOTH_EN defined:
  - A scanner visits one (channel, param) slot per cycle, round-robin over N_CHANNELS*N_PARAMS slots.
  - On each visit, current moves toward target by min(|target-current|, SMOOTH_STEP).
  - CLEAR writes current directly and does not ramp.
- PARAM_SMOOTH_EN undefined:
  - current is written together with target in the same cycle.
  - The scanner and SMOOTH_STEP are unused.

## Structure
- The PARAMETER package holds:
  - the parameter index enum;
  - PARAM_CC[N_PARAMS] (MSB controller numbers, all below 32);
  - PARAM_DEFAULT[N_PARAMS];
  - CC_RESET_ALL = 121.
- message_t and CONTROL_CHANGE come from the MIDI package.
- One sub-module, param_slew: combinational step of current toward target, instantiated only under PARAM_SMOOTH_EN.

## Test plan
- After reset, read every slot: each equals PARAM_DEFAULT[p]; busy=0; update_valid=0.
- CC channel 1, TEMPO MSB = 10, then LSB = 5:
  - update_valid pulses twice with channel 1, param TEMPO;
  - rd_value reads 1285;
  - channel 0 TEMPO still reads its default.
- CC to channel N_CHANNELS (4), NOTE_ON, unmapped CC 90, and an LSB with no prior MSB: no update_valid pulse and all slots unchanged.
- Interleaved pairs: ATTACK MSB = 30, then DECAY MSB = 40, then ATTACK LSB = 1. The ATTACK LSB is ignored, so ATTACK reads 3840 and DECAY reads 5120.
- Channel 2 slots set to non-default values, then CC 121 on channel 2:
  - busy is high for 7 cycles with 7 update pulses for p=0..6;
  - channel 2 slots return to defaults, other channels are untouched;
  - a CC sent while busy is dropped.
- With PARAM_SMOOTH_EN defined, VOLUME 0 -> MSB 127 (16256): current increases by 64 every N_CHANNELS*N_PARAMS cycles and reaches 16256 exactly without overshoot. Assert reset mid-ramp: VOLUME returns to its default.
